// File: rtl/render_dispatch_n_if.sv
// Handshake bundle between the frame dispatcher and its ray cores.
// The dispatcher is the master; a core array (or bench model) is the slave.
interface render_dispatch_n_if #(
  parameter int NUM_CORES = 4,
  parameter int COORD_W   = 11
) ();
  logic [NUM_CORES-1:0]         core_idle;
  logic [NUM_CORES-1:0]         core_done;
  logic [NUM_CORES-1:0]         core_strobe;
  logic [NUM_CORES*COORD_W-1:0] core_x;
  logic [NUM_CORES*COORD_W-1:0] core_y;

  modport master (
    input  core_idle, core_done,
    output core_strobe, core_x, core_y
  );

  modport slave (
    output core_idle, core_done,
    input  core_strobe, core_x, core_y
  );
endinterface

// File: rtl/render_dispatch_n.sv
// Frame dispatcher: walks the framebuffer in raster order and hands one pixel
// per cycle to the lowest-index free ray core, then drains and flips buffers.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | parked, waiting for enable
// WAIT_VSYNC | armed; starts a frame once vsync is low and all cores idle
// DISPATCH   | issuing pixels in raster order to free cores
// DRAIN      | last pixel issued; waiting for every core to finish
module render_dispatch_n #(
  parameter int NUM_CORES = 4,
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int COORD_W   = 11
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                vsync,
  render_dispatch_n_if.master cores,
  output logic                frame_start,
  output logic                frame_done,
  output logic                frame_flip,
  output logic [4:0]          frame_count,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, WAIT_VSYNC, DISPATCH, DRAIN} state_t;

  state_t                       state;
  logic [NUM_CORES-1:0]         pending;
  logic [NUM_CORES-1:0]         eligible;
  logic [NUM_CORES-1:0]         grant;
  logic [NUM_CORES-1:0]         strobeR;
  logic [NUM_CORES*COORD_W-1:0] xR;
  logic [NUM_CORES*COORD_W-1:0] yR;
  logic [COORD_W-1:0]           pixX;
  logic [COORD_W-1:0]           pixY;
  logic                         lastX;
  logic                         lastPixel;
  logic                         issue;

  // Isolate the lowest set bit: one-hot grant to the lowest free core.
  assign eligible  = ~pending;
  assign grant     = eligible & (~eligible + NUM_CORES'(1));
  assign issue     = (state == DISPATCH) && (|eligible);
  assign lastX     = (pixX == COORD_W'(FB_WIDTH - 1));
  assign lastPixel = lastX && (pixY == COORD_W'(FB_HEIGHT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      pending     <= '0;
      strobeR     <= '0;
      xR          <= '0;
      yR          <= '0;
      pixX        <= '0;
      pixY        <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_flip  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      strobeR     <= '0;

      // A strobe on the same edge wins over a stale done from the previous pixel.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (issue && grant[i]) begin
          pending[i]                <= 1'b1;
          strobeR[i]                <= 1'b1;
          xR[i*COORD_W +: COORD_W]  <= pixX;
          yR[i*COORD_W +: COORD_W]  <= pixY;
        end else if (cores.core_done[i]) begin
          pending[i] <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (enable) state <= WAIT_VSYNC;
        end
        WAIT_VSYNC: begin
          if (!enable) begin
            state <= IDLE;
          end else if (!vsync && (&cores.core_idle)) begin
            state       <= DISPATCH;
            pixX        <= '0;
            pixY        <= '0;
            frame_flip  <= ~frame_flip;
            frame_start <= 1'b1;
          end
        end
        DISPATCH: begin
          if (issue) begin
            if (lastPixel) begin
              state <= DRAIN;
            end else if (lastX) begin
              pixX <= '0;
              pixY <= pixY + COORD_W'(1);
            end else begin
              pixX <= pixX + COORD_W'(1);
            end
          end
        end
        DRAIN: begin
          if (pending == '0) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 5'd1;
            state       <= WAIT_VSYNC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cores.core_strobe = strobeR;
  assign cores.core_x      = xR;
  assign cores.core_y      = yR;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_render_dispatch_n.sv
// Directed bench for render_dispatch_n: three instances (1 core 4x2,
// 4 cores 8x4, 1 core 2x1) each served by a fixed-latency core model.
module tb_render_dispatch_n;
  localparam int CW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- instance A: 1 core, 4x2, done 3 cycles after strobe
  logic       rstA = 1'b0, enA = 1'b0, vsA = 1'b1;
  logic       doneA = 1'b0, idleA = 1'b1;
  int         cntA = 0;
  logic       fsA, fdA, flA, busyA;
  logic [4:0] fcA;
  render_dispatch_n_if #(.NUM_CORES(1), .COORD_W(CW)) ifA ();
  assign ifA.core_done = doneA;
  assign ifA.core_idle = idleA;
  render_dispatch_n #(.NUM_CORES(1), .FB_WIDTH(4), .FB_HEIGHT(2), .COORD_W(CW)) dutA (
    .clk(clk), .resetn(rstA), .enable(enA), .vsync(vsA), .cores(ifA),
    .frame_start(fsA), .frame_done(fdA), .frame_flip(flA), .frame_count(fcA), .busy(busyA));

  always @(posedge clk) begin
    #1;
    if (ifA.core_strobe[0]) begin
      doneA = 1'b0;
      cntA  = 3;
    end else if (cntA > 0) begin
      cntA--;
      if (cntA == 0) doneA = 1'b1;
    end
  end

  // ---------------- instance B: 4 cores, 8x4, done 2 cycles after strobe
  logic       rstB = 1'b0, enB = 1'b0, vsB = 1'b1;
  logic [3:0] doneB = '0, idleB = 4'hF;
  int         cntB [4] = '{default: 0};
  logic       fsB, fdB, flB, busyB;
  logic [4:0] fcB;
  render_dispatch_n_if #(.NUM_CORES(4), .COORD_W(CW)) ifB ();
  assign ifB.core_done = doneB;
  assign ifB.core_idle = idleB;
  render_dispatch_n #(.NUM_CORES(4), .FB_WIDTH(8), .FB_HEIGHT(4), .COORD_W(CW)) dutB (
    .clk(clk), .resetn(rstB), .enable(enB), .vsync(vsB), .cores(ifB),
    .frame_start(fsB), .frame_done(fdB), .frame_flip(flB), .frame_count(fcB), .busy(busyB));

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ifB.core_strobe[i]) begin
        doneB[i] = 1'b0;
        cntB[i]  = 2;
      end else if (cntB[i] > 0) begin
        cntB[i]--;
        if (cntB[i] == 0) doneB[i] = 1'b1;
      end
    end
  end

  // ---------------- instance C: 1 core, 2x1, done 1 cycle after strobe
  logic       rstC = 1'b0, enC = 1'b0, vsC = 1'b1;
  logic       doneC = 1'b0, idleC = 1'b1;
  int         cntC = 0;
  logic       fsC, fdC, flC, busyC;
  logic [4:0] fcC;
  render_dispatch_n_if #(.NUM_CORES(1), .COORD_W(CW)) ifC ();
  assign ifC.core_done = doneC;
  assign ifC.core_idle = idleC;
  render_dispatch_n #(.NUM_CORES(1), .FB_WIDTH(2), .FB_HEIGHT(1), .COORD_W(CW)) dutC (
    .clk(clk), .resetn(rstC), .enable(enC), .vsync(vsC), .cores(ifC),
    .frame_start(fsC), .frame_done(fdC), .frame_flip(flC), .frame_count(fcC), .busy(busyC));

  always @(posedge clk) begin
    #1;
    if (ifC.core_strobe[0]) begin
      doneC = 1'b0;
      cntC  = 1;
    end else if (cntC > 0) begin
      cntC--;
      if (cntC == 0) doneC = 1'b1;
    end
  end

  // ---------------- scenarios
  task automatic test_reset();
    checks++;
    if ({busyA, fsA, fdA, flA, fcA, ifA.core_strobe} !== 10'd0 || ifA.core_x !== '0 || ifA.core_y !== '0) begin
      errors++;
      $display("FAIL reset_A busy=%b fs=%b fd=%b flip=%b cnt=%0d strobe=%b x=%0d y=%0d required all zero",
               busyA, fsA, fdA, flA, fcA, ifA.core_strobe, ifA.core_x, ifA.core_y);
    end
    checks++;
    if ({busyB, fsB, fdB, flB, fcB, ifB.core_strobe} !== 13'd0 || ifB.core_x !== '0 || ifB.core_y !== '0) begin
      errors++;
      $display("FAIL reset_B busy=%b fs=%b fd=%b flip=%b cnt=%0d strobe=%b x=%h y=%h required all zero",
               busyB, fsB, fdB, flB, fcB, ifB.core_strobe, ifB.core_x, ifB.core_y);
    end
    checks++;
    if ({busyC, fsC, fdC, flC, fcC, ifC.core_strobe} !== 10'd0 || ifC.core_x !== '0 || ifC.core_y !== '0) begin
      errors++;
      $display("FAIL reset_C busy=%b fs=%b fd=%b flip=%b cnt=%0d strobe=%b required all zero",
               busyC, fsC, fdC, flC, fcC, ifC.core_strobe);
    end
  endtask

  task automatic test_single_core();
    int k = 0;
    int nd = 0;
    enA = 1'b1;
    vsA = 1'b0;
    for (int c = 0; c < 300 && nd == 0; c++) begin
      @(negedge clk);
      if (ifA.core_strobe[0]) begin
        checks++;
        if (ifA.core_x !== CW'(k % 4) || ifA.core_y !== CW'(k / 4)) begin
          errors++;
          $display("FAIL single_coord pixel=%0d got (%0d,%0d) required (%0d,%0d)",
                   k, ifA.core_x, ifA.core_y, k % 4, k / 4);
        end
        k++;
      end
      if (fdA) begin
        nd++;
        enA = 1'b0;
      end
    end
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL single_frame_done got %0d frame_done pulses required 1 (timeout)", nd);
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL single_strobes got %0d required 8", k);
    end
    checks++;
    if (fcA !== 5'd1) begin
      errors++;
      $display("FAIL single_count got %0d required 1", fcA);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busyA !== 1'b0) begin
      errors++;
      $display("FAIL single_idle busy=%b required 0", busyA);
    end
  endtask

  task automatic test_vsync_gate();
    logic sawStart = 1'b0;
    logic gotStart = 1'b0;
    enB   = 1'b1;
    vsB   = 1'b1;
    idleB = 4'hF;
    repeat (10) begin
      @(negedge clk);
      if (fsB) sawStart = 1'b1;
    end
    checks++;
    if (sawStart !== 1'b0 || busyB !== 1'b1) begin
      errors++;
      $display("FAIL vsync_high start=%b busy=%b required start=0 busy=1", sawStart, busyB);
    end
    vsB   = 1'b0;
    idleB = 4'b1011;
    repeat (10) begin
      @(negedge clk);
      if (fsB) sawStart = 1'b1;
    end
    checks++;
    if (sawStart !== 1'b0 || flB !== 1'b0) begin
      errors++;
      $display("FAIL core_not_idle start=%b flip=%b required start=0 flip=0", sawStart, flB);
    end
    idleB = 4'hF;
    for (int c = 0; c < 10 && !gotStart; c++) begin
      @(negedge clk);
      if (fsB) begin
        gotStart = 1'b1;
        checks++;
        if (flB !== 1'b1) begin
          errors++;
          $display("FAIL start_flip got %b required 1", flB);
        end
      end
    end
    checks++;
    if (!gotStart) begin
      errors++;
      $display("FAIL start_pulse got none required one frame_start (timeout)");
    end
  endtask

  task automatic test_rotation();
    int k = 0;
    int cyc = 0;
    int lastCyc = 0;
    int doneCyc = -1;
    int idx;
    logic [3:0] expS;
    for (int c = 0; c < 400 && doneCyc < 0; c++) begin
      @(negedge clk);
      cyc++;
      if (|ifB.core_strobe) begin
        idx  = k % 4;
        expS = 4'b0001 << idx;
        checks++;
        if (ifB.core_strobe !== expS) begin
          errors++;
          $display("FAIL rot_core pixel=%0d strobe=%b required %b", k, ifB.core_strobe, expS);
        end
        checks++;
        if (ifB.core_x[idx*CW +: CW] !== CW'(k % 8) || ifB.core_y[idx*CW +: CW] !== CW'(k / 8)) begin
          errors++;
          $display("FAIL rot_coord pixel=%0d got (%0d,%0d) required (%0d,%0d)", k,
                   ifB.core_x[idx*CW +: CW], ifB.core_y[idx*CW +: CW], k % 8, k / 8);
        end
        k++;
        lastCyc = cyc;
      end
      if (k == 12) enB = 1'b0;
      if (fdB) doneCyc = cyc;
    end
    checks++;
    if (k != 32) begin
      errors++;
      $display("FAIL rot_strobes got %0d required 32", k);
    end
    checks++;
    if (doneCyc - lastCyc != 4) begin
      errors++;
      $display("FAIL rot_drain frame_done %0d cycles after last strobe required 4 (doneCyc=%0d)",
               doneCyc - lastCyc, doneCyc);
    end
    checks++;
    if (fcB !== 5'd1) begin
      errors++;
      $display("FAIL rot_count got %0d required 1", fcB);
    end
  endtask

  task automatic test_enable_drop();
    logic sawStart = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (fsB) sawStart = 1'b1;
    end
    checks++;
    if (busyB !== 1'b0 || sawStart !== 1'b0 || fcB !== 5'd1) begin
      errors++;
      $display("FAIL enable_drop busy=%b start=%b count=%0d required busy=0 start=0 count=1",
               busyB, sawStart, fcB);
    end
  endtask

  task automatic test_reset_midframe();
    int k = 0;
    logic hit = 1'b0;
    logic gotFirst = 1'b0;
    enB = 1'b1;
    vsB = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      if (|ifB.core_strobe) begin
        if (k == 21) begin
          hit = 1'b1;
          checks++;
          if (ifB.core_strobe !== 4'b0010 || ifB.core_x[CW +: CW] !== CW'(5) || ifB.core_y[CW +: CW] !== CW'(2)) begin
            errors++;
            $display("FAIL mid_pixel strobe=%b got (%0d,%0d) required core1 (5,2)",
                     ifB.core_strobe, ifB.core_x[CW +: CW], ifB.core_y[CW +: CW]);
          end
        end
        k++;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_reach got %0d strobes required pixel 21 (timeout)", k);
    end
    rstB = 1'b0;
    #1;
    checks++;
    if ({busyB, fsB, fdB, flB, fcB, ifB.core_strobe} !== 13'd0 || ifB.core_x !== '0 || ifB.core_y !== '0) begin
      errors++;
      $display("FAIL mid_reset busy=%b fs=%b fd=%b flip=%b cnt=%0d strobe=%b x=%h y=%h required all zero",
               busyB, fsB, fdB, flB, fcB, ifB.core_strobe, ifB.core_x, ifB.core_y);
    end
    @(negedge clk);
    rstB = 1'b1;
    for (int c = 0; c < 20 && !gotFirst; c++) begin
      @(negedge clk);
      if (|ifB.core_strobe) begin
        gotFirst = 1'b1;
        checks++;
        if (ifB.core_strobe !== 4'b0001 || ifB.core_x[0 +: CW] !== CW'(0) || ifB.core_y[0 +: CW] !== CW'(0) || flB !== 1'b1) begin
          errors++;
          $display("FAIL post_reset strobe=%b got (%0d,%0d) flip=%b required core0 (0,0) flip=1",
                   ifB.core_strobe, ifB.core_x[0 +: CW], ifB.core_y[0 +: CW], flB);
        end
      end
    end
    checks++;
    if (!gotFirst) begin
      errors++;
      $display("FAIL post_reset_start got no strobe required one (timeout)");
    end
    enB = 1'b0;
  endtask

  task automatic test_wrap();
    int starts = 0;
    int dones  = 0;
    logic expF;
    enC = 1'b1;
    vsC = 1'b0;
    for (int c = 0; c < 3000 && dones < 33; c++) begin
      @(negedge clk);
      if (fsC) begin
        expF = ((starts + 1) % 2) == 1;
        checks++;
        if (flC !== expF) begin
          errors++;
          $display("FAIL wrap_flip frame=%0d got %b required %b", starts + 1, flC, expF);
        end
        starts++;
      end
      if (fdC) begin
        dones++;
        checks++;
        if (fcC !== 5'(dones % 32)) begin
          errors++;
          $display("FAIL wrap_count frame=%0d got %0d required %0d", dones, fcC, dones % 32);
        end
        if (dones == 33) enC = 1'b0;
      end
    end
    checks++;
    if (dones != 33 || fcC !== 5'd1) begin
      errors++;
      $display("FAIL wrap_final frames=%0d count=%0d required frames=33 count=1", dones, fcC);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rstA = 1'b1;
    rstB = 1'b1;
    rstC = 1'b1;
    @(negedge clk);
    test_single_core();
    test_vsync_gate();
    test_rotation();
    test_enable_drop();
    test_reset_midframe();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
